baud_gen_frac: RTL and testbench
================================

BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Interface
REQ-001 Parameter DIV_W, default 16, integer divisor width, legal range 9..16.
REQ-002 Parameter FRAC_W, default 4, fractional divisor width, legal range 1..8.
REQ-003 Parameter OSR, default 16, oversample ratio (rx ticks per bit), power of two, minimum 2.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 enable  input  1  global enable; low SHALL hold all state, ignore writes and force every output to 0.
REQ-007 wrt  input  1  register write strobe, sampled when enable=1.
REQ-008 addr  input  2  register select: 0=div low byte, 1=div high bits, 2=frac, 3=control.
REQ-009 data  input  8  write data.
REQ-010 rx_sync  input  1  rx phase restart pulse, for example on start-bit edge.
REQ-011 clr_tx_baud  input  1  tx phase restart pulse.
REQ-012 rx_baud_en  output  1  one-cycle oversample tick.
REQ-013 rx_mid_en  output  1  one-cycle bit-centre tick, once per OSR rx ticks.
REQ-014 tx_baud_en  output  1  one-cycle bit tick, once per OSR rx ticks.
REQ-015 running  output  1  high when enable=1 and active divisor is nonzero.

Function
REQ-016 The block SHALL keep shadow registers sh_div[DIV_W-1:0] and sh_frac[FRAC_W-1:0], written as follows:
- addr0: data[7:0] to sh_div[7:0].
- addr1: data[DIV_W-9:0] to sh_div[DIV_W-1:8].
- addr2: data[FRAC_W-1:0] to sh_frac.
REQ-017 Shadow writes SHALL NOT disturb the active divisor, counters or outputs.
REQ-018 A write to addr3 with data[0]=1 (commit) SHALL, on that edge:
- copy shadow to active (D, F);
- set the rx period counter to 1;
- clear the accumulator, carry, rx_sub and tx_sub.
REQ-019 A write to addr3 with data[0]=0 SHALL have no effect.
REQ-020 No output tick SHALL be asserted in a commit cycle.
REQ-021 The rx period counter SHALL be DIV_W+1 bits, count 1..P, and return to 1 after reaching P.
REQ-022 P SHALL equal D+carry.
REQ-023 rx_baud_en SHALL equal (counter==P) && running && no commit && no rx_sync in that cycle.
REQ-024 On each rx tick, {carry,acc} SHALL be loaded with acc+F (FRAC_W+1-bit result), setting P for the following period.
REQ-025 The average rx period SHALL be D+F/2^FRAC_W cycles.
REQ-026 The first period after commit or rx_sync SHALL be exactly D.
REQ-027 tx_sub (log2(OSR) bits) SHALL increment on each rx tick and wrap at OSR-1 to 0.
REQ-028 tx_baud_en SHALL equal rx_baud_en && (tx_sub==OSR-1).
REQ-029 clr_tx_baud SHALL clear tx_sub only.
REQ-030 After clr_tx_baud, the next tx tick SHALL occur on the OSR-th subsequent rx tick.
REQ-031 clr_tx_baud coincident with an rx tick SHALL cause tx_sub to take 0 and SHALL suppress tx_baud_en.
REQ-032 rx_sub (log2(OSR) bits) SHALL behave identically to tx_sub but SHALL be cleared by rx_sync.
REQ-033 rx_mid_en SHALL equal rx_baud_en && (rx_sub==OSR/2-1).
REQ-034 rx_sync SHALL set the rx counter to 1 and clear acc, carry and rx_sub.
REQ-035 rx_sync SHALL NOT affect tx_sub.
REQ-036 With D==0:
- counters SHALL hold at their reset values;
- all ticks SHALL be 0;
- running SHALL be 0.
REQ-037 If commit, rx_sync and clr_tx_baud coincide, commit SHALL take precedence; the resulting state equals commit alone.
REQ-038 When enable falls, all state SHALL freeze, and counting SHALL resume from the frozen state when enable rises.

Reset
REQ-039 On rst_n=0 the following SHALL be cleared immediately:
- sh_div, sh_frac, D, F;
- acc, carry, rx_sub, tx_sub.
REQ-040 On rst_n=0 the rx counter SHALL be set to 1.
REQ-041 Reset SHALL force all outputs to 0, with running=0.
REQ-042 Reset asserted mid-operation SHALL abandon the current period.
REQ-043 No tick SHALL occur until a nonzero divisor is committed.

Verification
REQ-044 Default parameters: write D=4 (addr0=0x04, addr1=0x00), F=0, then commit -> rx_baud_en every 4 cycles and tx_baud_en every 64 cycles. The first rx tick occurs 4 cycles after the commit edge.
REQ-045 D=4, F=8 -> rx periods are 4,4,5,4,5,...; the average over 32 ticks is 4.5 cycles.
REQ-046 While running at D=4, write shadow D=10 without commit -> period stays 4. After commit, the period becomes 10 and the counters restart.
REQ-047 D=4; assert rx_sync mid-period -> next rx tick exactly 4 cycles later, first rx_mid_en on the 8th rx tick after sync, tx_baud_en cadence unchanged in rx-tick count.
REQ-048 clr_tx_baud coincident with an rx tick where tx_sub=15 -> no tx tick that cycle; next tx tick 16 rx ticks later.
REQ-049 Deassert enable for 7 cycles mid-period -> outputs 0, counters frozen, period resumes with the remaining count. Then assert rst_n=0 -> all outputs 0 and running=0 with no further ticks.

Source files
------------

// File: rtl/baud_gen_frac.sv
// Fractional baud generator: rx oversample tick with average period D + F/2^FRAC_W
// cycles, plus derived rx bit-centre and tx bit ticks, all from one clock.
module baud_gen_frac #(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned FRAC_W = 4,
  parameter int unsigned OSR    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       wrt,
  input  logic [1:0] addr,
  input  logic [7:0] data,
  input  logic       rx_sync,
  input  logic       clr_tx_baud,
  output logic       rx_baud_en,
  output logic       rx_mid_en,
  output logic       tx_baud_en,
  output logic       running
);

  localparam int unsigned CNT_W = DIV_W + 1;
  localparam int unsigned SUB_W = (OSR > 2) ? $clog2(OSR) : 1;
  localparam int unsigned ACC_W = FRAC_W + 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OSR - 1);
  localparam logic [SUB_W-1:0] SUB_MID  = SUB_W'(OSR / 2 - 1);

  logic [DIV_W-1:0]  sh_div;
  logic [FRAC_W-1:0] sh_frac;
  logic [DIV_W-1:0]  div_q;
  logic [FRAC_W-1:0] frac_q;
  logic [FRAC_W-1:0] acc;
  logic              carry;
  logic [CNT_W-1:0]  cnt;
  logic [SUB_W-1:0]  rx_sub;
  logic [SUB_W-1:0]  tx_sub;

  logic              commit;
  logic              active;
  logic [CNT_W-1:0]  period;
  logic              rx_tick;

  // Period of the current rx interval stretches by one whenever the accumulator carried.
  always_comb begin
    commit  = enable && wrt && (addr == 2'd3) && data[0];
    active  = enable && (div_q != '0);
    period  = CNT_W'(div_q) + CNT_W'(carry);
    rx_tick = active && (cnt == period) && !commit && !rx_sync;
  end

  assign rx_baud_en = rx_tick;
  assign rx_mid_en  = rx_tick && (rx_sub == SUB_MID);
  assign tx_baud_en = rx_tick && (tx_sub == SUB_LAST) && !clr_tx_baud;
  assign running    = active;

  // Shadow divisor registers; they only reach the counters on a commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_div  <= '0;
      sh_frac <= '0;
    end else if (enable && wrt) begin
      case (addr)
        2'd0:    sh_div[7:0]       <= data;
        2'd1:    sh_div[DIV_W-1:8] <= data[DIV_W-9:0];
        2'd2:    sh_frac           <= data[FRAC_W-1:0];
        default: ;
      endcase
    end
  end

  // Active divisor, period counter, fractional accumulator and tick sub-counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      frac_q <= '0;
      cnt    <= CNT_W'(1);
      acc    <= '0;
      carry  <= 1'b0;
      rx_sub <= '0;
      tx_sub <= '0;
    end else if (enable) begin
      if (commit) begin
        div_q  <= sh_div;
        frac_q <= sh_frac;
        cnt    <= CNT_W'(1);
        acc    <= '0;
        carry  <= 1'b0;
        rx_sub <= '0;
        tx_sub <= '0;
      end else begin
        if (rx_sync) begin
          cnt    <= CNT_W'(1);
          acc    <= '0;
          carry  <= 1'b0;
          rx_sub <= '0;
        end else if (rx_tick) begin
          cnt          <= CNT_W'(1);
          {carry, acc} <= ACC_W'(acc) + ACC_W'(frac_q);
          rx_sub       <= rx_sub + SUB_W'(1);
        end else if (active) begin
          cnt <= cnt + CNT_W'(1);
        end

        // A restart coinciding with a tick wins, so tx_sub lands on 0.
        if (clr_tx_baud) begin
          tx_sub <= '0;
        end else if (rx_tick) begin
          tx_sub <= tx_sub + SUB_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: tick times are logged by cycle number and
// compared with hand-computed periods for each scenario.
module tb_baud_gen_frac;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       wrt;
  logic [1:0] addr;
  logic [7:0] data;
  logic       rx_sync;
  logic       clr_tx_baud;
  logic       rx_baud_en;
  logic       rx_mid_en;
  logic       tx_baud_en;
  logic       running;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rx_cnt   = 0;
  int last_wr  = 0;
  int rx_q[$];
  int tx_i[$];
  int mid_i[$];

  baud_gen_frac dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .wrt         (wrt),
    .addr        (addr),
    .data        (data),
    .rx_sync     (rx_sync),
    .clr_tx_baud (clr_tx_baud),
    .rx_baud_en  (rx_baud_en),
    .rx_mid_en   (rx_mid_en),
    .tx_baud_en  (tx_baud_en),
    .running     (running)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Log rx tick cycle numbers; tx and mid ticks are logged as rx tick indices.
  initial forever begin
    @(negedge clk);
    if (rx_baud_en === 1'b1) begin
      rx_cnt++;
      rx_q.push_back(cyc);
    end
    if (tx_baud_en === 1'b1) tx_i.push_back(rx_cnt);
    if (rx_mid_en === 1'b1) mid_i.push_back(rx_cnt);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
    wrt     = 1'b1;
    addr    = a;
    data    = d;
    last_wr = cyc;
    step();
    wrt = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic wait_rx(input int n, input int max);
    int k;
    k = 0;
    while (rx_q.size() < n && k < max) begin
      step();
      k++;
    end
    n_checks++;
    if (rx_q.size() < n) begin
      n_fail++;
      $display("FAIL wait_rx: got %0d rx ticks, required %0d within %0d cycles", rx_q.size(), n, max);
    end
  endtask

  task automatic clear_log();
    rx_q.delete();
    tx_i.delete();
    mid_i.delete();
    rx_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; wrt = 1'b0; addr = 2'd0; data = 8'h00;
    rx_sync = 1'b0; clr_tx_baud = 1'b0;
    #2;
    n_checks++;
    if ({rx_baud_en, tx_baud_en, rx_mid_en, running} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, expected 0000", {rx_baud_en, tx_baud_en, rx_mid_en, running});
    end
    step(); step();
    rst_n = 1'b1;
    step();
    clear_log();
    write_reg(2'd0, 8'h04);
    write_reg(2'd1, 8'h00);
    repeat (20) step();
    n_checks++;
    if (rx_q.size() !== 0 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL no_commit_idle: got %0d ticks running=%b, expected 0 ticks running=0", rx_q.size(), running);
    end
  endtask

  task automatic test_basic();
    int c;
    write_reg(2'd2, 8'h00);
    clear_log();
    write_reg(2'd3, 8'h01);
    c = last_wr;
    n_checks++;
    if (running !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_running: got %b, expected 1", running);
    end
    wait_rx(32, 200);
    n_checks++;
    if (rx_q[0] - c !== 4) begin
      n_fail++;
      $display("FAIL basic_first_tick: got %0d cycles after commit, expected 4", rx_q[0] - c);
    end
    for (int i = 1; i < 32; i++) begin
      n_checks++;
      if (rx_q[i] - rx_q[i-1] !== 4) begin
        n_fail++;
        $display("FAIL basic_period[%0d]: got %0d, expected 4", i, rx_q[i] - rx_q[i-1]);
      end
    end
    n_checks++;
    if (tx_i.size() !== 2 || tx_i[0] !== 16 || tx_i[1] !== 32) begin
      n_fail++;
      $display("FAIL basic_tx_index: got n=%0d first=%0d, expected n=2 at 16,32", tx_i.size(), tx_i[0]);
    end
    n_checks++;
    if (rx_q[31] - rx_q[15] !== 64) begin
      n_fail++;
      $display("FAIL basic_tx_period: got %0d cycles, expected 64", rx_q[31] - rx_q[15]);
    end
    n_checks++;
    if (mid_i.size() !== 2 || mid_i[0] !== 8 || mid_i[1] !== 24) begin
      n_fail++;
      $display("FAIL basic_mid_index: got n=%0d first=%0d, expected n=2 at 8,24", mid_i.size(), mid_i[0]);
    end
  endtask

  task automatic test_shadow();
    int prev_t;
    int t;
    int c;
    prev_t = rx_q[$];
    clear_log();
    write_reg(2'd0, 8'd10);
    write_reg(2'd3, 8'h02);
    wait_rx(6, 100);
    n_checks++;
    if (rx_q[0] - prev_t !== 4) begin
      n_fail++;
      $display("FAIL shadow_undisturbed: got %0d, expected 4", rx_q[0] - prev_t);
    end
    for (int i = 1; i < 6; i++) begin
      n_checks++;
      if (rx_q[i] - rx_q[i-1] !== 4) begin
        n_fail++;
        $display("FAIL shadow_period[%0d]: got %0d, expected 4", i, rx_q[i] - rx_q[i-1]);
      end
    end
    t = rx_q[$];
    wait_until(t + 4);
    write_reg(2'd3, 8'h01);
    c = last_wr;
    n_checks++;
    if (rx_q[$] !== t) begin
      n_fail++;
      $display("FAIL commit_no_tick: got last tick at %0d, expected %0d", rx_q[$], t);
    end
    clear_log();
    wait_rx(16, 250);
    n_checks++;
    if (rx_q[0] - c !== 10 || rx_q[1] - rx_q[0] !== 10) begin
      n_fail++;
      $display("FAIL shadow_new_period: got %0d,%0d, expected 10,10", rx_q[0] - c, rx_q[1] - rx_q[0]);
    end
    n_checks++;
    if (tx_i.size() !== 1 || tx_i[0] !== 16) begin
      n_fail++;
      $display("FAIL shadow_tx_restart: got n=%0d first=%0d, expected n=1 at 16", tx_i.size(), tx_i[0]);
    end
  endtask

  task automatic test_frac();
    int c;
    int exp_p;
    write_reg(2'd0, 8'h04);
    write_reg(2'd2, 8'h08);
    write_reg(2'd3, 8'h01);
    c = last_wr;
    clear_log();
    wait_rx(33, 300);
    n_checks++;
    if (rx_q[0] - c !== 4) begin
      n_fail++;
      $display("FAIL frac_first: got %0d, expected 4", rx_q[0] - c);
    end
    for (int k = 2; k <= 33; k++) begin
      exp_p = (k % 2 == 0) ? 4 : 5;
      n_checks++;
      if (rx_q[k-1] - rx_q[k-2] !== exp_p) begin
        n_fail++;
        $display("FAIL frac_period[%0d]: got %0d, expected %0d", k, rx_q[k-1] - rx_q[k-2], exp_p);
      end
    end
    n_checks++;
    if (rx_q[32] - rx_q[0] !== 144) begin
      n_fail++;
      $display("FAIL frac_32_periods: got %0d cycles, expected 144", rx_q[32] - rx_q[0]);
    end
  endtask

  task automatic test_rx_sync();
    int t;
    int s;
    write_reg(2'd2, 8'h00);
    write_reg(2'd3, 8'h01);
    clear_log();
    wait_rx(3, 50);
    t = rx_q[$];
    wait_until(t + 2);
    rx_sync = 1'b1;
    s = cyc;
    step();
    rx_sync = 1'b0;
    clear_log();
    wait_rx(16, 200);
    n_checks++;
    if (rx_q[0] - s !== 4) begin
      n_fail++;
      $display("FAIL sync_next_tick: got %0d, expected 4", rx_q[0] - s);
    end
    n_checks++;
    if (mid_i.size() < 1 || mid_i[0] !== 8) begin
      n_fail++;
      $display("FAIL sync_mid_index: got %0d, expected 8", mid_i[0]);
    end
    n_checks++;
    if (tx_i.size() < 1 || tx_i[0] !== 13) begin
      n_fail++;
      $display("FAIL sync_tx_index: got %0d, expected 13", tx_i[0]);
    end
  endtask

  task automatic test_clr_tx();
    int c;
    write_reg(2'd3, 8'h01);
    c = last_wr;
    clear_log();
    wait_until(c + 64);
    clr_tx_baud = 1'b1;
    step();
    clr_tx_baud = 1'b0;
    wait_rx(32, 200);
    n_checks++;
    if (rx_q[15] !== c + 64) begin
      n_fail++;
      $display("FAIL clr_rx_tick: got %0d, expected %0d", rx_q[15], c + 64);
    end
    n_checks++;
    if (tx_i.size() !== 1 || tx_i[0] !== 32) begin
      n_fail++;
      $display("FAIL clr_tx_index: got n=%0d first=%0d, expected n=1 at 32", tx_i.size(), tx_i[0]);
    end
    n_checks++;
    if (mid_i.size() !== 2 || mid_i[0] !== 8 || mid_i[1] !== 24) begin
      n_fail++;
      $display("FAIL clr_mid_index: got n=%0d first=%0d, expected n=2 at 8,24", mid_i.size(), mid_i[0]);
    end
  endtask

  task automatic test_precedence();
    int n0;
    int t;
    int pc;
    write_reg(2'd0, 8'h06);
    n0 = rx_q.size();
    wait_rx(n0 + 1, 20);
    t = rx_q[$];
    wait_until(t + 4);
    wrt = 1'b1; addr = 2'd3; data = 8'h01; rx_sync = 1'b1; clr_tx_baud = 1'b1;
    pc = cyc;
    step();
    wrt = 1'b0; rx_sync = 1'b0; clr_tx_baud = 1'b0;
    n_checks++;
    if (rx_q[$] !== t) begin
      n_fail++;
      $display("FAIL prec_no_tick: got last tick at %0d, expected %0d", rx_q[$], t);
    end
    clear_log();
    wait_rx(16, 200);
    n_checks++;
    if (rx_q[0] - pc !== 6 || rx_q[1] - rx_q[0] !== 6) begin
      n_fail++;
      $display("FAIL prec_period: got %0d,%0d, expected 6,6", rx_q[0] - pc, rx_q[1] - rx_q[0]);
    end
    n_checks++;
    if (tx_i.size() !== 1 || tx_i[0] !== 16 || mid_i[0] !== 8) begin
      n_fail++;
      $display("FAIL prec_sub: got tx n=%0d at %0d mid %0d, expected tx n=1 at 16 mid 8", tx_i.size(), tx_i[0], mid_i[0]);
    end
  endtask

  task automatic test_enable_reset();
    int t;
    int t2;
    int n0;
    write_reg(2'd0, 8'h04);
    write_reg(2'd3, 8'h01);
    clear_log();
    wait_rx(2, 30);
    t = rx_q[$];
    wait_until(t + 2);
    for (int i = 0; i < 7; i++) begin
      enable      = 1'b0;
      wrt         = (i == 2);
      addr        = 2'd3;
      data        = 8'h01;
      rx_sync     = (i == 3);
      clr_tx_baud = (i == 3);
      #1;
      n_checks++;
      if ({rx_baud_en, tx_baud_en, rx_mid_en, running} !== 4'b0000) begin
        n_fail++;
        $display("FAIL disabled_outputs[%0d]: got %b, expected 0000", i, {rx_baud_en, tx_baud_en, rx_mid_en, running});
      end
      step();
    end
    wrt = 1'b0; rx_sync = 1'b0; clr_tx_baud = 1'b0; enable = 1'b1;
    wait_rx(4, 40);
    n_checks++;
    if (rx_q[2] !== t + 11 || rx_q[3] !== t + 15) begin
      n_fail++;
      $display("FAIL enable_resume: got %0d,%0d, expected %0d,%0d", rx_q[2], rx_q[3], t + 11, t + 15);
    end
    t2 = rx_q[$];
    wait_until(t2 + 2);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rx_baud_en, tx_baud_en, rx_mid_en, running} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrun_reset: got %b, expected 0000", {rx_baud_en, tx_baud_en, rx_mid_en, running});
    end
    n0 = rx_q.size();
    repeat (5) step();
    rst_n = 1'b1;
    repeat (20) step();
    n_checks++;
    if (rx_q.size() !== n0 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %0d new ticks running=%b, expected 0 running=0", rx_q.size() - n0, running);
    end
    write_reg(2'd3, 8'h01);
    repeat (20) step();
    n_checks++;
    if (rx_q.size() !== n0 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_div_commit: got %0d new ticks running=%b, expected 0 running=0", rx_q.size() - n0, running);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shadow();
    test_frac();
    test_rx_sync();
    test_clr_tx();
    test_precedence();
    test_enable_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
